injector_run_scheduler: RTL and testbench

INJECTOR_RUN_SCHEDULER -- requirements
Module: injector_run_scheduler

---
 rtl/injector_run_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_injector_run_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/injector_run_scheduler.sv
// injector_run_scheduler: issues a batch of ap_ctrl_hs core invocations.
// A batch is started by cmd_start and counted in runs_done. cmd_abort stops the
// batch after the invocation in flight. The optional per-invocation watchdog is
// compiled in by defining INJECTOR_RUN_SCHED_WDOG_EN.
module injector_run_scheduler #(
    parameter int CNT_W  = 16,
    parameter int WDOG_W = 20
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cmd_start,
    input  logic [CNT_W-1:0]  cmd_runs,
    input  logic              cmd_abort,
    input  logic [WDOG_W-1:0] wdog_limit,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic              busy,
    output logic              batch_done,
    output logic [CNT_W-1:0]  runs_done,
    output logic              wdog_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   runs_q, runs_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               abort_q, abort_d;
    logic               gap_q, gap_d;
    logic               ap_start_q, ap_start_d;
    logic               busy_q, busy_d;
    logic               batch_done_q, batch_done_d;
    logic [CNT_W:0]     runs_inc_s;
    logic               last_s;
    logic               abort_now_s;
    logic               accept_s;
    logic               timeout_s;
    logic               wdog_fire_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    assign runs_inc_s  = {1'b0, runs_q} + (CNT_W+1)'(1);
    assign last_s      = (runs_inc_s == {1'b0, target_q});
    assign abort_now_s = abort_q | cmd_abort;
    // A zero-length batch finishes immediately and does not need the core.
    assign accept_s    = (state_q == S_IDLE) && cmd_start &&
                         ((cmd_runs == '0) || ap_idle);

    // State and registered outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            runs_q       <= '0;
            target_q     <= '0;
            abort_q      <= 1'b0;
            gap_q        <= 1'b0;
            ap_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            runs_q       <= runs_d;
            target_q     <= target_d;
            abort_q      <= abort_d;
            gap_q        <= gap_d;
            ap_start_q   <= ap_start_d;
            busy_q       <= busy_d;
            batch_done_q <= batch_done_d;
        end
    end

    // Next state, run counting and abort bookkeeping.
    always_comb begin
        state_d     = state_q;
        runs_d      = runs_q;
        target_d    = target_q;
        abort_d     = abort_q;
        gap_d       = gap_q;
        wdog_fire_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                gap_d   = 1'b0;
                if (accept_s) begin
                    runs_d   = '0;
                    target_d = cmd_runs;
                    if (cmd_runs == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                abort_d = abort_now_s;
                if (ap_ready && ap_done) begin
                    // Combinational core: accepted and finished in one cycle;
                    // a WAIT cycle with gap set keeps ap_start low once.
                    runs_d = sat_inc(runs_q);
                    if (last_s || abort_now_s) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_WAIT;
                        gap_d   = 1'b1;
                    end
                end else if (ap_ready) begin
                    state_d = S_WAIT;
                end else if (timeout_s) begin
                    state_d     = S_FINISH;
                    wdog_fire_s = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                abort_d = abort_now_s;
                if (gap_q) begin
                    gap_d = 1'b0;
                    if (abort_now_s) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (ap_done) begin
                    runs_d = sat_inc(runs_q);
                    if (last_s || abort_now_s) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (timeout_s) begin
                    state_d     = S_FINISH;
                    wdog_fire_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                abort_d = 1'b0;
                gap_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                abort_d = 1'b0;
                gap_d   = 1'b0;
            end
        endcase
    end

    // Moore outputs derived from the upcoming state so they can be registered.
    always_comb begin
        ap_start_d   = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
        batch_done_d = (state_d == S_FINISH);
    end

`ifdef INJECTOR_RUN_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [WDOG_W:0]   wdog_inc_s;
    logic              wdog_err_q, wdog_err_d;

    assign wdog_inc_s = {1'b0, wdog_cnt_q} + (WDOG_W+1)'(1);
    assign timeout_s  = (wdog_limit != '0) && (wdog_inc_s >= {1'b0, wdog_limit});

    // Per-invocation cycle counter and sticky timeout flag.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        wdog_err_d = wdog_err_q;
        if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) begin
            wdog_cnt_d = '0;
        end else if (((state_q == S_ISSUE) || (state_q == S_WAIT)) && !wdog_inc_s[WDOG_W]) begin
            wdog_cnt_d = wdog_inc_s[WDOG_W-1:0];
        end else begin
            wdog_cnt_d = wdog_cnt_q;
        end
        if (accept_s) begin
            wdog_err_d = 1'b0;
        end else if (wdog_fire_s) begin
            wdog_err_d = 1'b1;
        end else begin
            wdog_err_d = wdog_err_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic unused_wdog_s;

    assign timeout_s     = 1'b0;
    assign wdog_err      = 1'b0;
    assign unused_wdog_s = ^{wdog_limit, wdog_fire_s};
`endif

    assign ap_start   = ap_start_q;
    assign busy       = busy_q;
    assign batch_done = batch_done_q;
    assign runs_done  = runs_q;

endmodule

// File: tb/tb_injector_run_scheduler.sv
// Self-checking bench for injector_run_scheduler: a behavioural core model
// answers the ap_ctrl_hs handshake with configurable latencies while the
// expected batch outcome is derived from the batch parameters.
module tb_injector_run_scheduler;
    localparam int CNT_W  = 16;
    localparam int WDOG_W = 20;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              cmd_start = 1'b0;
    logic [CNT_W-1:0]  cmd_runs = '0;
    logic              cmd_abort = 1'b0;
    logic [WDOG_W-1:0] wdog_limit = '0;
    logic              ap_ready = 1'b0;
    logic              ap_done = 1'b0;
    logic              ap_idle = 1'b1;
    logic              ap_start, busy, batch_done, wdog_err;
    logic [CNT_W-1:0]  runs_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ap_clk = ~ap_clk;

    injector_run_scheduler #(.CNT_W(CNT_W), .WDOG_W(WDOG_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_start(cmd_start),
        .cmd_runs(cmd_runs), .cmd_abort(cmd_abort), .wdog_limit(wdog_limit),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_idle(ap_idle), .busy(busy), .batch_done(batch_done),
        .runs_done(runs_done), .wdog_err(wdog_err)
    );

    task automatic test_reset();
        ap_rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({ap_start, busy, batch_done, wdog_err} !== 4'b0000 || runs_done !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: got start=%b busy=%b bd=%b werr=%b runs=%0d want all 0",
                     ap_start, busy, batch_done, wdog_err, runs_done);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_cmp++;
        if ({ap_start, busy, batch_done, wdog_err} !== 4'b0000 || runs_done !== '0) begin
            n_bad++;
            $display("FAIL reset_release: got start=%b busy=%b bd=%b werr=%b runs=%0d want all 0",
                     ap_start, busy, batch_done, wdog_err, runs_done);
        end
    endtask

    // Runs one batch against a core model. r = cycles from ap_start to ap_ready,
    // d = cycles from accept to ap_done (0 = same cycle). mode: 0 no abort,
    // 1 abort while waiting on invocation k, 2 abort before ready of invocation k.
    // rst_at > 0: assert reset while waiting with rst_at invocations complete.
    task automatic run_batch(input int n, input int r_in, input int d, input int mode_in,
                             input int k, input int rst_at, input int exp_cycles,
                             input string tag);
        int  r = r_in;
        int  mode = mode_in;
        int  exp_runs;
        int  phase = 0;
        int  cnt = 0;
        int  completed = 0;
        int  starts = 0;
        int  inv = 0;
        int  s = 0;
        logic prev = 1'b0;
        bit  done = 1'b0;
        bit  did_rst = 1'b0;
        if (mode == 1 && d == 0) mode = 2;
        if (mode == 2 && r == 0) r = 1;
        exp_runs = (mode != 0 && k >= 1 && k <= n) ? k : n;
        @(negedge ap_clk);
        cmd_start = 1'b1;
        cmd_runs  = n[CNT_W-1:0];
        ap_idle   = 1'b1;
        for (s = 0; s < 400 && !done && !did_rst; s++) begin
            @(negedge ap_clk);
            cmd_start = 1'b0;
            cmd_abort = 1'b0;
            ap_ready  = 1'b0;
            ap_done   = 1'b0;
            n_cmp++;
            if (runs_done !== completed[CNT_W-1:0]) begin
                n_bad++;
                $display("FAIL %s runs_track: cycle %0d got %0d want %0d", tag, s, runs_done, completed);
            end
            if (batch_done === 1'b1) begin
                done = 1'b1;
                n_cmp++;
                if (runs_done !== exp_runs[CNT_W-1:0] || starts != exp_runs) begin
                    n_bad++;
                    $display("FAIL %s final_runs: got runs=%0d starts=%0d want %0d",
                             tag, runs_done, starts, exp_runs);
                end
                n_cmp++;
                if (ap_start !== 1'b0 || busy !== 1'b1 || wdog_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s finish_outs: got start=%b busy=%b werr=%b want 0 1 0",
                             tag, ap_start, busy, wdog_err);
                end
                if (exp_cycles >= 0) begin
                    n_cmp++;
                    if (s != exp_cycles) begin
                        n_bad++;
                        $display("FAIL %s batch_latency: got %0d want %0d", tag, s, exp_cycles);
                    end
                end
            end else begin
                if (s == 0 && n > 0) begin
                    n_cmp++;
                    if (ap_start !== 1'b1) begin
                        n_bad++;
                        $display("FAIL %s start_latency: got ap_start=%b want 1", tag, ap_start);
                    end
                end
                if (phase == 1) begin
                    n_cmp++;
                    if (ap_start !== 1'b1) begin
                        n_bad++;
                        $display("FAIL %s start_hold: cycle %0d got %b want 1", tag, s, ap_start);
                    end
                end else if (phase == 2) begin
                    n_cmp++;
                    if (ap_start !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s start_drop: cycle %0d got %b want 0", tag, s, ap_start);
                    end
                end
                if (ap_start === 1'b1 && prev === 1'b0) starts++;
                prev = ap_start;
                if (rst_at > 0 && completed == rst_at && phase == 2) begin
                    #2;
                    ap_rst_n = 1'b0;
                    did_rst  = 1'b1;
                end else begin
                    if (s == 3) begin
                        cmd_start = 1'b1;
                        cmd_runs  = CNT_W'(7);
                    end
                    if (phase == 0 && ap_start === 1'b1) begin
                        phase = 1;
                        cnt   = r;
                        inv++;
                        if (mode == 2 && inv == k) cmd_abort = 1'b1;
                    end
                    if (phase == 1) begin
                        if (cnt == 0) begin
                            ap_ready = 1'b1;
                            if (d == 0) begin
                                ap_done = 1'b1;
                                phase   = 0;
                                completed++;
                            end else begin
                                phase = 2;
                                cnt   = d;
                            end
                        end else begin
                            cnt--;
                        end
                    end else if (phase == 2) begin
                        if (mode == 1 && inv == k && cnt == d) cmd_abort = 1'b1;
                        cnt--;
                        if (cnt == 0) begin
                            ap_done = 1'b1;
                            phase   = 0;
                            completed++;
                        end
                    end
                end
            end
        end
        if (!did_rst) begin
            n_cmp++;
            if (!done) begin
                n_bad++;
                $display("FAIL %s batch_timeout: got no batch_done want pulse", tag);
            end
            @(negedge ap_clk);
            n_cmp++;
            if (busy !== 1'b0 || batch_done !== 1'b0 || runs_done !== exp_runs[CNT_W-1:0]) begin
                n_bad++;
                $display("FAIL %s after_finish: got busy=%b bd=%b runs=%0d want 0 0 %0d",
                         tag, busy, batch_done, runs_done, exp_runs);
            end
        end
    endtask

    task automatic test_directed();
        run_batch(3, 0, 4, 0, 0, 0, 15, "three_runs");
        run_batch(0, 0, 0, 0, 0, 0, 0, "zero_runs");
        run_batch(5, 0, 3, 1, 2, 0, -1, "abort_wait");
        run_batch(4, 2, 2, 2, 3, 0, -1, "abort_issue");
        run_batch(4, 0, 0, 0, 0, 0, 7, "comb_core");
    endtask

    task automatic test_start_gating();
        @(negedge ap_clk);
        cmd_abort = 1'b1;
        ap_idle   = 1'b0;
        cmd_start = 1'b1;
        cmd_runs  = CNT_W'(3);
        @(negedge ap_clk);
        cmd_abort = 1'b0;
        cmd_start = 1'b0;
        ap_idle   = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || ap_start !== 1'b0) begin
            n_bad++;
            $display("FAIL core_busy_gate: got busy=%b start=%b want 0 0", busy, ap_start);
        end
        run_batch(3, 1, 1, 0, 0, 0, -1, "after_idle_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int n = $urandom_range(1, 6);
            run_batch(n, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2),
                      $urandom_range(1, n + 1), 0, -1, "random");
        end
    endtask

    task automatic test_reset_mid();
        run_batch(5, 0, 4, 0, 0, 2, -1, "rst_mid");
        #1;
        n_cmp++;
        if ({ap_start, busy, batch_done, wdog_err} !== 4'b0000 || runs_done !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got start=%b busy=%b bd=%b werr=%b runs=%0d want all 0",
                     ap_start, busy, batch_done, wdog_err, runs_done);
        end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            n_cmp++;
            if (batch_done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset_quiet: got bd=%b busy=%b want 0 0", batch_done, busy);
            end
        end
        run_batch(2, 1, 2, 0, 0, 0, -1, "post_reset");
    endtask

`ifdef INJECTOR_RUN_SCHED_WDOG_EN
    task automatic test_wdog();
        int hi = 0;
        bit seen = 1'b0;
        wdog_limit = WDOG_W'(10);
        @(negedge ap_clk);
        cmd_start = 1'b1;
        cmd_runs  = CNT_W'(2);
        for (int s = 0; s < 40 && !seen; s++) begin
            @(negedge ap_clk);
            cmd_start = 1'b0;
            if (batch_done === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (s != 10 || hi != 10 || wdog_err !== 1'b1 || ap_start !== 1'b0 || runs_done !== '0) begin
                    n_bad++;
                    $display("FAIL wdog_timeout: got cyc=%0d hi=%0d werr=%b start=%b runs=%0d want 10 10 1 0 0",
                             s, hi, wdog_err, ap_start, runs_done);
                end
            end else if (ap_start === 1'b1) begin
                hi++;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL wdog_no_finish: got no batch_done want pulse");
        end
        wdog_limit = '0;
        @(negedge ap_clk);
        n_cmp++;
        if (wdog_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_sticky: got werr=%b busy=%b want 1 0", wdog_err, busy);
        end
        run_batch(2, 0, 1, 0, 0, 0, -1, "wdog_clear");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_start_gating();
        test_random();
        test_reset_mid();
`ifdef INJECTOR_RUN_SCHED_WDOG_EN
        test_wdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
